// File: rtl/tex_commit_arb.sv
// Commit arbiter for the texture response path.
// Texture responses are buffered in a small FIFO and arbitrated round-robin
// against the SFU response path into one registered commit port.
module tex_commit_arb #(
   parameter int NUM_THREADS = 4,
   parameter int NW_BITS     = 2,
   parameter int NR_BITS     = 5,
   parameter int DEPTH       = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   // texture response
   input  logic                          tex_valid,
   input  logic [NUM_THREADS-1:0]        tex_tmask,
   input  logic [NUM_THREADS*32-1:0]     tex_data,
   input  logic [NR_BITS-1:0]            tex_rd,
   input  logic                          tex_wb,
   input  logic [NW_BITS-1:0]            tex_wid,
   input  logic [31:0]                   tex_PC,
   output logic                          tex_ready,
   // SFU response
   input  logic                          sfu_valid,
   input  logic [NUM_THREADS-1:0]        sfu_tmask,
   input  logic [NUM_THREADS*32-1:0]     sfu_data,
   input  logic [NR_BITS-1:0]            sfu_rd,
   input  logic                          sfu_wb,
   input  logic [NW_BITS-1:0]            sfu_wid,
   input  logic [31:0]                   sfu_PC,
   output logic                          sfu_ready,
   // commit port
   output logic                          cmt_valid,
   output logic [NUM_THREADS-1:0]        cmt_tmask,
   output logic [NUM_THREADS*32-1:0]     cmt_data,
   output logic [NR_BITS-1:0]            cmt_rd,
   output logic                          cmt_wb,
   output logic [NW_BITS-1:0]            cmt_wid,
   output logic [31:0]                   cmt_PC,
   input  logic                          cmt_ready,
   output logic [$clog2(DEPTH+1)-1:0]    tex_pending
);

   localparam int PW = NUM_THREADS + NUM_THREADS*32 + NR_BITS + 1 + NW_BITS + 32;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   // storage and state
   logic [PW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_last_g;      // 0: tex granted last, 1: sfu granted last
   logic          r_cmt_valid;
   logic [PW-1:0] r_cmt_pay;

   // combinational nets
   logic [PW-1:0] w_tex_pay;
   logic [PW-1:0] w_sfu_pay;
   logic [PW-1:0] w_head_pay;
   logic [PW-1:0] w_gnt_pay;
   logic          w_push;
   logic          w_pop_tex;
   logic          w_ld;
   logic          w_cand_tex;
   logic          w_cand_sfu;
   logic          w_gnt_valid;
   logic          w_gnt_sfu;

   assign w_tex_pay  = {tex_tmask, tex_data, tex_rd, tex_wb, tex_wid, tex_PC};
   assign w_sfu_pay  = {sfu_tmask, sfu_data, sfu_rd, sfu_wb, sfu_wid, sfu_PC};
   assign w_head_pay = r_mem[r_rd_ptr];

   // Full is judged from occupancy alone, so a pop never frees a slot in the same cycle.
   assign tex_ready  = (r_count != CW'(DEPTH));
   assign w_push     = tex_valid && tex_ready;
   assign w_cand_tex = (r_count != {CW{1'b0}});
   assign w_cand_sfu = sfu_valid;
   assign w_ld       = !r_cmt_valid || cmt_ready;

   // Round-robin grant: on a tie the source that did not win last time is chosen.
   always_comb begin
      w_gnt_valid = 1'b0;
      w_gnt_sfu   = 1'b0;
      case ({w_cand_tex, w_cand_sfu})
         2'b11: begin
            w_gnt_valid = 1'b1;
            w_gnt_sfu   = ~r_last_g;
         end
         2'b10: begin
            w_gnt_valid = 1'b1;
            w_gnt_sfu   = 1'b0;
         end
         2'b01: begin
            w_gnt_valid = 1'b1;
            w_gnt_sfu   = 1'b1;
         end
         default: begin
            w_gnt_valid = 1'b0;
            w_gnt_sfu   = 1'b0;
         end
      endcase
   end

   assign w_gnt_pay = w_gnt_sfu ? w_sfu_pay : w_head_pay;
   assign w_pop_tex = w_ld && w_gnt_valid && !w_gnt_sfu;
   assign sfu_ready = !reset && w_ld && w_gnt_valid && w_gnt_sfu;

   // FIFO storage write; contents are not cleared on reset, the pointers are.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_tex_pay;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop_tex) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop_tex})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Commit output register and round-robin history; holds while writeback stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cmt_valid <= 1'b0;
         r_cmt_pay   <= {PW{1'b0}};
         r_last_g    <= 1'b1;
      end else if (w_ld) begin
         if (w_gnt_valid) begin
            r_cmt_valid <= 1'b1;
            r_cmt_pay   <= w_gnt_pay;
            r_last_g    <= w_gnt_sfu;
         end else begin
            r_cmt_valid <= 1'b0;
         end
      end
   end

   assign cmt_valid = r_cmt_valid;
   assign {cmt_tmask, cmt_data, cmt_rd, cmt_wb, cmt_wid, cmt_PC} = r_cmt_pay;
   assign tex_pending = r_count;

endmodule

// File: tb/tb_tex_commit_arb.sv
// Self-checking bench for tex_commit_arb: randomized payloads checked against
// a queue-based model of the buffering and round-robin commit rules.
module tb_tex_commit_arb;

   localparam int NT    = 4;
   localparam int NWB   = 2;
   localparam int NRB   = 5;
   localparam int DEPTH = 4;
   localparam int PW    = NT + NT*32 + NRB + 1 + NWB + 32;
   localparam int CW    = $clog2(DEPTH+1);
   typedef logic [PW-1:0] pay_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset     = 1'b1;
   logic tex_valid = 1'b0;
   logic sfu_valid = 1'b0;
   logic cmt_ready = 1'b0;
   pay_t tex_pay   = '0;
   pay_t sfu_pay   = '0;

   logic [NT-1:0]    tex_tmask, sfu_tmask, cmt_tmask;
   logic [NT*32-1:0] tex_data,  sfu_data,  cmt_data;
   logic [NRB-1:0]   tex_rd,    sfu_rd,    cmt_rd;
   logic             tex_wb,    sfu_wb,    cmt_wb;
   logic [NWB-1:0]   tex_wid,   sfu_wid,   cmt_wid;
   logic [31:0]      tex_PC,    sfu_PC,    cmt_PC;
   logic             tex_ready, sfu_ready, cmt_valid;
   logic [CW-1:0]    tex_pending;

   assign {tex_tmask, tex_data, tex_rd, tex_wb, tex_wid, tex_PC} = tex_pay;
   assign {sfu_tmask, sfu_data, sfu_rd, sfu_wb, sfu_wid, sfu_PC} = sfu_pay;

   pay_t dut_pay;
   assign dut_pay = {cmt_tmask, cmt_data, cmt_rd, cmt_wb, cmt_wid, cmt_PC};
   logic [CW+2:0] got_status;
   assign got_status = {cmt_valid, tex_ready, sfu_ready, tex_pending};

   tex_commit_arb #(.NUM_THREADS(NT), .NW_BITS(NWB), .NR_BITS(NRB), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .tex_valid(tex_valid), .tex_tmask(tex_tmask), .tex_data(tex_data), .tex_rd(tex_rd),
      .tex_wb(tex_wb), .tex_wid(tex_wid), .tex_PC(tex_PC), .tex_ready(tex_ready),
      .sfu_valid(sfu_valid), .sfu_tmask(sfu_tmask), .sfu_data(sfu_data), .sfu_rd(sfu_rd),
      .sfu_wb(sfu_wb), .sfu_wid(sfu_wid), .sfu_PC(sfu_PC), .sfu_ready(sfu_ready),
      .cmt_valid(cmt_valid), .cmt_tmask(cmt_tmask), .cmt_data(cmt_data), .cmt_rd(cmt_rd),
      .cmt_wb(cmt_wb), .cmt_wid(cmt_wid), .cmt_PC(cmt_PC), .cmt_ready(cmt_ready),
      .tex_pending(tex_pending)
   );

   int checks   = 0;
   int failures = 0;

   // stimulus sources, reference model state, observed commits
   pay_t tex_src[$];
   pay_t sfu_src[$];
   pay_t m_q[$];
   pay_t observed[$];
   bit   tex_en  = 1'b1;
   bit   sfu_en  = 1'b1;
   bit   m_valid = 1'b0;
   pay_t m_out   = '0;
   bit   m_last  = 1'b1;   // 1: sfu won last (so tex wins the next tie)

   function automatic pay_t mk(input logic [31:0] pc);
      pay_t p;
      p = {NT'($urandom), $urandom, $urandom, $urandom, $urandom,
           NRB'($urandom), 1'($urandom), NWB'($urandom), pc};
      return p;
   endfunction

   // 0 none, 1 tex, 2 sfu
   function automatic int m_grant();
      bit t;
      t = (m_q.size() != 0);
      if (t && sfu_valid) return m_last ? 1 : 2;
      else if (t) return 1;
      else if (sfu_valid) return 2;
      else return 0;
   endfunction

   function automatic logic [CW+2:0] exp_status();
      logic sr;
      sr = !reset && (!m_valid || cmt_ready) && (m_grant() == 2);
      return {m_valid, (m_q.size() < DEPTH), sr, CW'(m_q.size())};
   endfunction

   function automatic bit all_done();
      return tex_src.size() == 0 && sfu_src.size() == 0 && m_q.size() == 0 && !m_valid;
   endfunction

   task automatic present();
      tex_valid = tex_en && (tex_src.size() != 0);
      if (tex_valid) tex_pay = tex_src[0];
      else tex_pay = '0;
      sfu_valid = sfu_en && (sfu_src.size() != 0);
      if (sfu_valid) sfu_pay = sfu_src[0];
      else sfu_pay = '0;
      #1;
   endtask

   // apply one clock edge to the model and the stimulus sources
   task automatic advance();
      int  g;
      bit  can_push;
      if (reset) begin
         m_q.delete();
         m_valid = 1'b0;
         m_out   = '0;
         m_last  = 1'b1;
      end else begin
         if (cmt_valid && cmt_ready) observed.push_back(dut_pay);
         g = m_grant();
         can_push = (m_q.size() < DEPTH);
         if (!m_valid || cmt_ready) begin
            if (g == 1) begin
               m_out = m_q.pop_front(); m_valid = 1'b1; m_last = 1'b0;
            end else if (g == 2) begin
               m_out = sfu_pay; m_valid = 1'b1; m_last = 1'b1;
               void'(sfu_src.pop_front());
            end else begin
               m_valid = 1'b0;
            end
         end
         if (tex_valid && can_push) begin
            m_q.push_back(tex_pay);
            void'(tex_src.pop_front());
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      present(); advance(); advance();
      reset = 1'b0;
      present();
      checks++; if (cmt_valid !== 1'b0) begin failures++; $display("FAIL reset_cmt_valid got=%b required=0", cmt_valid); end
      checks++; if (dut_pay !== '0) begin failures++; $display("FAIL reset_payload got=%h required=0", dut_pay); end
      checks++; if (tex_ready !== 1'b1) begin failures++; $display("FAIL reset_tex_ready got=%b required=1", tex_ready); end
      checks++; if (sfu_ready !== 1'b0) begin failures++; $display("FAIL reset_sfu_ready got=%b required=0", sfu_ready); end
      checks++; if (tex_pending !== CW'(0)) begin failures++; $display("FAIL reset_pending got=%0d required=0", tex_pending); end
   endtask

   task automatic test_basic_latency();
      pay_t p;
      p = {4'b1011, 32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011,
           5'd3, 1'b1, 2'd2, 32'h0000_0100};
      cmt_ready = 1'b1;
      tex_src.push_back(p);
      present(); advance();          // accept in cycle N
      present();
      checks++; if (cmt_valid !== 1'b0 || tex_pending !== CW'(1)) begin
         failures++; $display("FAIL basic_n1 got valid=%b pending=%0d required valid=0 pending=1", cmt_valid, tex_pending);
      end
      advance();
      present();
      checks++; if (cmt_valid !== 1'b1) begin failures++; $display("FAIL basic_n2_valid got=%b required=1", cmt_valid); end
      checks++; if (dut_pay !== p) begin failures++; $display("FAIL basic_n2_payload got=%h required=%h", dut_pay, p); end
      advance();
      present();
      checks++; if (tex_pending !== CW'(0) || cmt_valid !== 1'b0) begin
         failures++; $display("FAIL basic_drain got valid=%b pending=%0d required valid=0 pending=0", cmt_valid, tex_pending);
      end
   endtask

   task automatic test_fill_full();
      observed.delete();
      cmt_ready = 1'b0;
      for (int i = 0; i < 6; i++) tex_src.push_back(mk(32'h200 + 32'(4*i)));
      for (int c = 0; c < 5; c++) begin
         present();
         checks++; if (got_status !== exp_status()) begin failures++; $display("FAIL fill_status got=%h required=%h", got_status, exp_status()); end
         advance();
      end
      present();
      checks++; if (tex_ready !== 1'b0 || tex_pending !== CW'(4)) begin
         failures++; $display("FAIL fill_full got ready=%b pending=%0d required ready=0 pending=4", tex_ready, tex_pending);
      end
      cmt_ready = 1'b1;
      for (int c = 0; c < 100 && !all_done(); c++) begin
         present();
         checks++; if (got_status !== exp_status()) begin failures++; $display("FAIL fill_drain_status got=%h required=%h", got_status, exp_status()); end
         if (m_valid) begin
            checks++; if (dut_pay !== m_out) begin failures++; $display("FAIL fill_payload got=%h required=%h", dut_pay, m_out); end
         end
         advance();
      end
      checks++; if (!all_done()) begin failures++; $display("FAIL fill_timeout got=not drained required=drained"); end
      checks++; if (observed.size() != 6) begin failures++; $display("FAIL fill_count got=%0d required=6", observed.size()); end
      for (int i = 0; i < observed.size() && i < 6; i++) begin
         checks++; if (observed[i][31:0] !== 32'h200 + 32'(4*i)) begin
            failures++; $display("FAIL fill_order[%0d] got=%h required=%h", i, observed[i][31:0], 32'h200 + 32'(4*i));
         end
      end
   endtask

   task automatic test_contention();
      logic [31:0] exp_pc [6];
      exp_pc = '{32'h300, 32'h400, 32'h304, 32'h404, 32'h308, 32'h408};
      reset = 1'b1; present(); advance(); reset = 1'b0;
      observed.delete();
      cmt_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tex_src.push_back(mk(32'h300 + 32'(4*i)));
         sfu_src.push_back(mk(32'h400 + 32'(4*i)));
      end
      sfu_en = 1'b0;
      for (int c = 0; c < 100 && !all_done(); c++) begin
         present();
         checks++; if (got_status !== exp_status()) begin failures++; $display("FAIL cont_status got=%h required=%h", got_status, exp_status()); end
         if (m_valid) begin
            checks++; if (dut_pay !== m_out) begin failures++; $display("FAIL cont_payload got=%h required=%h", dut_pay, m_out); end
         end
         advance();
         sfu_en = 1'b1;
      end
      present(); advance();          // let the last commit be observed
      checks++; if (observed.size() != 6) begin failures++; $display("FAIL cont_count got=%0d required=6", observed.size()); end
      for (int i = 0; i < observed.size() && i < 6; i++) begin
         checks++; if (observed[i][31:0] !== exp_pc[i]) begin
            failures++; $display("FAIL cont_order[%0d] got=%h required=%h", i, observed[i][31:0], exp_pc[i]);
         end
      end
   endtask

   task automatic test_back_pressure();
      int seen [int];
      int bad;
      observed.delete();
      for (int i = 0; i < 8; i++) begin
         tex_src.push_back(mk(32'h500 + 32'(4*i)));
         sfu_src.push_back(mk(32'h600 + 32'(4*i)));
      end
      for (int c = 0; c < 200 && !(all_done() && c % 4 == 0); c++) begin
         cmt_ready = (c % 4 == 0) || (c % 4 == 3);
         present();
         checks++; if (got_status !== exp_status()) begin failures++; $display("FAIL bp_status got=%h required=%h", got_status, exp_status()); end
         if (m_valid) begin
            checks++; if (dut_pay !== m_out) begin failures++; $display("FAIL bp_payload got=%h required=%h", dut_pay, m_out); end
         end
         if (cmt_valid && !cmt_ready) begin
            checks++; if (sfu_ready !== 1'b0) begin failures++; $display("FAIL bp_sfu_ready got=%b required=0", sfu_ready); end
         end
         advance();
      end
      checks++; if (!all_done()) begin failures++; $display("FAIL bp_timeout got=not drained required=drained"); end
      foreach (observed[i]) begin
         if (seen.exists(int'(observed[i][31:0]))) seen[int'(observed[i][31:0])]++;
         else seen[int'(observed[i][31:0])] = 1;
      end
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (!seen.exists(32'h500 + 4*i) || seen[32'h500 + 4*i] != 1) bad++;
         if (!seen.exists(32'h600 + 4*i) || seen[32'h600 + 4*i] != 1) bad++;
      end
      checks++; if (bad != 0 || observed.size() != 16) begin
         failures++; $display("FAIL bp_scoreboard got bad=%0d commits=%0d required bad=0 commits=16", bad, observed.size());
      end
   endtask

   task automatic test_wrap_around();
      pay_t sent[$];
      observed.delete();
      for (int i = 0; i < 20; i++) begin
         sent.push_back(mk(32'h700 + 32'(4*i)));
         tex_src.push_back(sent[i]);
      end
      for (int c = 0; c < 400 && !all_done(); c++) begin
         cmt_ready = 1'($urandom_range(0, 1));
         tex_en    = ($urandom_range(0, 3) != 0);
         present();
         checks++; if (got_status !== exp_status()) begin failures++; $display("FAIL wrap_status got=%h required=%h", got_status, exp_status()); end
         checks++; if (tex_pending > CW'(4)) begin failures++; $display("FAIL wrap_pending got=%0d required<=4", tex_pending); end
         if (m_valid) begin
            checks++; if (dut_pay !== m_out) begin failures++; $display("FAIL wrap_payload got=%h required=%h", dut_pay, m_out); end
         end
         advance();
      end
      tex_en = 1'b1;
      cmt_ready = 1'b1;
      present(); advance();
      checks++; if (!all_done()) begin failures++; $display("FAIL wrap_timeout got=not drained required=drained"); end
      checks++; if (observed.size() != 20) begin failures++; $display("FAIL wrap_count got=%0d required=20", observed.size()); end
      for (int i = 0; i < observed.size() && i < 20; i++) begin
         checks++; if (observed[i] !== sent[i]) begin
            failures++; $display("FAIL wrap_seq[%0d] got=%h required=%h", i, observed[i][31:0], sent[i][31:0]);
         end
      end
   endtask

   task automatic test_reset_mid_stream();
      cmt_ready = 1'b0;
      for (int i = 0; i < 4; i++) tex_src.push_back(mk(32'h800 + 32'(4*i)));
      for (int c = 0; c < 4; c++) begin present(); advance(); end
      present();
      checks++; if (cmt_valid !== 1'b1 || tex_pending !== CW'(3)) begin
         failures++; $display("FAIL rst_mid_pre got valid=%b pending=%0d required valid=1 pending=3", cmt_valid, tex_pending);
      end
      reset = 1'b1;
      present(); advance();
      reset = 1'b0;
      tex_src.delete();
      observed.delete();
      present();
      checks++; if (cmt_valid !== 1'b0 || tex_pending !== CW'(0) || tex_ready !== 1'b1) begin
         failures++; $display("FAIL rst_mid_post got valid=%b pending=%0d ready=%b required 0,0,1", cmt_valid, tex_pending, tex_ready);
      end
      for (int i = 0; i < 3; i++) tex_src.push_back(mk(32'h900 + 32'(4*i)));
      cmt_ready = 1'b1;
      for (int c = 0; c < 100 && !all_done(); c++) begin
         present();
         checks++; if (got_status !== exp_status()) begin failures++; $display("FAIL rst_mid_status got=%h required=%h", got_status, exp_status()); end
         advance();
      end
      present(); advance();
      checks++; if (observed.size() != 3) begin failures++; $display("FAIL rst_mid_count got=%0d required=3", observed.size()); end
      for (int i = 0; i < observed.size() && i < 3; i++) begin
         checks++; if (observed[i][31:0] !== 32'h900 + 32'(4*i)) begin
            failures++; $display("FAIL rst_mid_stale[%0d] got=%h required=%h", i, observed[i][31:0], 32'h900 + 32'(4*i));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_latency();
      test_fill_full();
      test_contention();
      test_back_pressure();
      test_wrap_around();
      test_reset_mid_stream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
